// File: rtl/pixel_readout_ctrl_if.sv
// Pixel readout stream: one captured pixel word per handshake,
// tagged with its pixel index.
interface pixel_readout_ctrl_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned IW = 2
);
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pixel_readout_ctrl.sv
// Pixel-array bus master: drives the ramp during convert, captures pixel
// values during read, then streams the frame out over valid/ready.
module pixel_readout_ctrl #(
  parameter int unsigned N_PIX    = 4,
  parameter int unsigned DW       = 8,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                convert_i,
  input  logic                read_i,
  output logic [DW-1:0]       ramp_o,
  output logic                ramp_oe,
  input  logic [N_PIX*DW-1:0] pix_bus_i,
  pixel_readout_ctrl_if.master out_if,
  output logic                frame_done,
  output logic                overflow,
  output logic                protocol_err
);

  localparam int unsigned    IW       = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(N_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_cap [N_PIX];
  logic [DW-1:0] r_buf [N_PIX];
  logic          r_read_d;
  logic [IW-1:0] r_idx;

  logic          w_end_of_read;
  logic          w_load;
  logic [IW-1:0] w_idx_nxt;

  assign ramp_oe       = ~read_i;
  assign w_end_of_read = ~read_i & r_read_d;
  // A new frame is accepted unless one is still being drained.
  assign w_load        = w_end_of_read & (r_state != S_DRAIN);
  assign w_idx_nxt     = r_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_o <= '0;
    end else if (convert_i && !read_i) begin
      if (ramp_o == '1) begin
        ramp_o <= SATURATE ? ramp_o : '0;
      end else begin
        ramp_o <= ramp_o + 1'b1;
      end
    end else begin
      ramp_o <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (convert_i && read_i) begin
      protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read_d <= 1'b0;
      for (int unsigned k = 0; k < N_PIX; k++) begin
        r_cap[k] <= '0;
        r_buf[k] <= '0;
      end
    end else begin
      r_read_d <= read_i;
      for (int unsigned k = 0; k < N_PIX; k++) begin
        if (read_i) begin
          r_cap[k] <= pix_bus_i[k*DW +: DW];
        end
        if (w_load) begin
          r_buf[k] <= r_cap[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_idx            <= '0;
      out_if.out_data  <= '0;
      out_if.out_idx   <= '0;
      out_if.out_valid <= 1'b0;
      frame_done       <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (w_load) begin
        // r_cap is stable on this edge (read_i is low), so word 0 comes from it directly.
        r_state          <= S_DRAIN;
        r_idx            <= '0;
        out_if.out_data  <= r_cap[0];
        out_if.out_idx   <= '0;
        out_if.out_valid <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            out_if.out_valid <= 1'b0;
          end
          S_DRAIN: begin
            if (w_end_of_read) begin
              overflow <= 1'b1;
            end
            if (out_if.out_valid && out_if.out_ready) begin
              if (r_idx == LAST_IDX) begin
                r_state          <= S_DONE;
                out_if.out_valid <= 1'b0;
                frame_done       <= 1'b1;
              end else begin
                r_idx           <= w_idx_nxt;
                out_if.out_data <= r_buf[w_idx_nxt];
                out_if.out_idx  <= w_idx_nxt;
              end
            end
          end
          S_DONE: begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            out_if.out_idx <= '0;
          end
          default: begin
            r_state          <= S_IDLE;
            out_if.out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
